// File: rtl/retry_llrb_if.sv
// Port bundle between the retry buffer and its producers/consumers.
// slave = retry buffer side; master = CRC generator / TX MUX / controller side.
interface retry_llrb_if #(parameter int FLIT_W = 528);
  logic              i_wr_en;
  logic [FLIT_W-1:0] i_flit_w_crc;
  logic              i_ack_valid;
  logic [7:0]        i_ack_num;
  logic              i_replay_req;
  logic              i_rd_en;
  logic [7:0]        i_llr_wrap_value;
  logic [FLIT_W-1:0] o_llrb_flit;
  logic              o_llrb_valid;
  logic              o_replay_active;
  logic              o_replay_done;
  logic [7:0]        o_wrt_ptr;
  logic [7:0]        o_eseq;
  logic [8:0]        o_num_free_buff;
  logic [8:0]        o_consumed;
  logic              o_full;
  logic              o_empty;
  logic              o_wr_err;
  logic              o_ack_err;

  modport slave (
    input  i_wr_en, i_flit_w_crc, i_ack_valid, i_ack_num, i_replay_req, i_rd_en, i_llr_wrap_value,
    output o_llrb_flit, o_llrb_valid, o_replay_active, o_replay_done, o_wrt_ptr, o_eseq,
           o_num_free_buff, o_consumed, o_full, o_empty, o_wr_err, o_ack_err
  );

  modport master (
    output i_wr_en, i_flit_w_crc, i_ack_valid, i_ack_num, i_replay_req, i_rd_en, i_llr_wrap_value,
    input  o_llrb_flit, o_llrb_valid, o_replay_active, o_replay_done, o_wrt_ptr, o_eseq,
           o_num_free_buff, o_consumed, o_full, o_empty, o_wr_err, o_ack_err
  );
endinterface

// File: rtl/retry_llrb.sv
// Link-layer retry buffer: holds transmitted flits until acked and replays
// the unacknowledged window in order on request.
module retry_llrb #(
  parameter int FLIT_W = 528,
  parameter int DEPTH  = 256
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  retry_llrb_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REPLAY, FLUSH} state_e;

  logic [FLIT_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [7:0]        wrap_q, wrap_d;
  logic [7:0]        wr_ptr_q, wr_ptr_d;
  logic [7:0]        eseq_q, eseq_d;
  logic [7:0]        rd_ptr_q, rd_ptr_d;
  logic [8:0]        count_q, count_d;
  logic [8:0]        remain_q, remain_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              wr_err_q, wr_err_d;
  logic              ack_err_q, ack_err_d;

  logic [8:0] depth, ack_n, eseq_sum, eseq_wrapped;
  logic       full, empty, wr_ok;

  function automatic logic [7:0] ptr_inc(input logic [7:0] p, input logic [7:0] w);
    return (p == w) ? 8'd0 : p + 8'd1;
  endfunction

  always_comb begin
    depth = {1'b0, wrap_q} + 9'd1;
    full  = (count_q == depth);
    empty = (count_q == 9'd0);
    wr_ok = bus.i_wr_en && !full && (state_q == IDLE);

    // Acks beyond the live count are clamped and flagged.
    ack_n     = 9'd0;
    ack_err_d = 1'b0;
    if (bus.i_ack_valid) begin
      if ({1'b0, bus.i_ack_num} > count_q) begin
        ack_n     = count_q;
        ack_err_d = 1'b1;
      end else begin
        ack_n = {1'b0, bus.i_ack_num};
      end
    end

    // eseq <= wrap and ack_n <= wrap+1, so one subtraction folds the sum back in range.
    eseq_sum     = {1'b0, eseq_q} + ack_n;
    eseq_wrapped = (eseq_sum >= depth) ? eseq_sum - depth : eseq_sum;
    eseq_d       = eseq_wrapped[7:0];

    count_d  = count_q - ack_n + {8'd0, wr_ok};
    wr_ptr_d = wr_ok ? ptr_inc(wr_ptr_q, wrap_q) : wr_ptr_q;
    wr_err_d = bus.i_wr_en && !wr_ok;
    wrap_d   = (state_q == IDLE && empty) ? bus.i_llr_wrap_value : wrap_q;

    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    remain_d = remain_q;
    flit_d   = flit_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_replay_req) begin
          if (!empty) begin
            rd_ptr_d = eseq_q;
            remain_d = count_q;
            state_d  = REPLAY;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      REPLAY: begin
        if (bus.i_rd_en) begin
          flit_d   = mem[rd_ptr_q];
          valid_d  = 1'b1;
          rd_ptr_d = ptr_inc(rd_ptr_q, wrap_q);
          remain_d = remain_q - 9'd1;
          // Done is registered alongside the last flit so both land in FLUSH.
          if (remain_q == 9'd1) begin
            state_d = FLUSH;
            done_d  = 1'b1;
          end
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      wrap_q    <= 8'hFF;
      wr_ptr_q  <= 8'd0;
      eseq_q    <= 8'd0;
      rd_ptr_q  <= 8'd0;
      count_q   <= 9'd0;
      remain_q  <= 9'd0;
      flit_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_err_q  <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wrap_q    <= wrap_d;
      wr_ptr_q  <= wr_ptr_d;
      eseq_q    <= eseq_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      remain_q  <= remain_d;
      flit_q    <= flit_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      wr_err_q  <= wr_err_d;
      ack_err_q <= ack_err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr_q] <= bus.i_flit_w_crc;
  end

  assign bus.o_llrb_flit     = flit_q;
  assign bus.o_llrb_valid    = valid_q;
  assign bus.o_replay_active = (state_q != IDLE);
  assign bus.o_replay_done   = done_q;
  assign bus.o_wrt_ptr       = wr_ptr_q;
  assign bus.o_eseq          = eseq_q;
  assign bus.o_num_free_buff = depth - count_q;
  assign bus.o_consumed      = count_q;
  assign bus.o_full          = full;
  assign bus.o_empty         = empty;
  assign bus.o_wr_err        = wr_err_q;
  assign bus.o_ack_err       = ack_err_q;

endmodule

// File: tb/tb_retry_llrb.sv
// Self-checking bench for retry_llrb: a queue-based model of the unacked
// window predicts counters, pointers, error pulses and replay contents.
module tb_retry_llrb;
  typedef logic [527:0] flit_t;

  logic i_clk, i_rst_n;
  retry_llrb_if #(.FLIT_W(528)) bus();
  retry_llrb #(.FLIT_W(528), .DEPTH(256)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errs = 0, checks = 0;

  // Model: unacked flits oldest-first, plus pointers as modular integers.
  flit_t m_q[$];
  int    m_wr, m_eseq, m_wrap;
  bit    e_werr, e_aerr;

  // Replay observations.
  flit_t obs_q[$];
  bit    r_done, r_coinc, r_first_active, r_active_after, r_valid_after, r_werr;
  int    r_active_bad;

  function automatic flit_t rand_flit();
    flit_t f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = $urandom;
    f[527:512] = 16'($urandom);
    return f;
  endfunction

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic clear_in();
    bus.i_wr_en = 0; bus.i_flit_w_crc = '0; bus.i_ack_valid = 0; bus.i_ack_num = 0;
    bus.i_replay_req = 0; bus.i_rd_en = 0;
  endtask

  // Model of one IDLE-state cycle, evaluated on pre-cycle state.
  task automatic mdl_step(input bit wr, input flit_t d, input bit av, input int an);
    int cnt = m_q.size();
    int n;
    e_werr = wr && !(cnt < m_wrap + 1);
    e_aerr = av && (an > cnt);
    n = av ? ((an < cnt) ? an : cnt) : 0;
    for (int i = 0; i < n; i++) void'(m_q.pop_front());
    m_eseq = (m_eseq + n) % (m_wrap + 1);
    if (wr && !e_werr) begin
      m_q.push_back(d);
      m_wr = (m_wr + 1) % (m_wrap + 1);
    end
    if (cnt == 0) m_wrap = int'(bus.i_llr_wrap_value);
  endtask

  task automatic cycle(input bit wr, input flit_t d, input bit av, input int an);
    bus.i_wr_en = wr; bus.i_flit_w_crc = d; bus.i_ack_valid = av; bus.i_ack_num = 8'(an);
    mdl_step(wr, d, av, an);
    tick();
    clear_in();
  endtask

  task automatic do_reset(input int wrap);
    clear_in();
    bus.i_llr_wrap_value = 8'(wrap);
    @(negedge i_clk); i_rst_n = 0;
    #7; i_rst_n = 1;
    m_q.delete(); m_wr = 0; m_eseq = 0; m_wrap = 255;
    cycle(0, '0, 0, 0);
  endtask

  // Drives a replay and records what came out; callers do the checking.
  task automatic run_replay(input bit toggle, input bit wr_mid);
    obs_q.delete(); r_done = 0; r_coinc = 0; r_active_bad = 0; r_werr = 0;
    bus.i_replay_req = 1; tick(); bus.i_replay_req = 0;
    r_first_active = bus.o_replay_active;
    for (int c = 0; c < 400; c++) begin
      bus.i_rd_en = toggle ? (c % 2 == 1) : 1'b1;
      if (wr_mid && c == 2) begin bus.i_wr_en = 1; bus.i_flit_w_crc = rand_flit(); end
      tick();
      bus.i_rd_en = 0; bus.i_wr_en = 0;
      if (wr_mid && c == 2) r_werr = bus.o_wr_err;
      if (!bus.o_replay_active) r_active_bad++;
      if (bus.o_llrb_valid) obs_q.push_back(bus.o_llrb_flit);
      if (bus.o_replay_done) begin r_done = 1; r_coinc = bus.o_llrb_valid; break; end
    end
    tick();
    r_active_after = bus.o_replay_active;
    r_valid_after  = bus.o_llrb_valid;
  endtask

  task automatic test_reset();
    clear_in();
    bus.i_llr_wrap_value = 8'h10;
    @(negedge i_clk); i_rst_n = 0; #3;
    checks++; if (bus.o_wrt_ptr !== 8'd0 || bus.o_eseq !== 8'd0 || bus.o_consumed !== 9'd0) begin errs++; $display("FAIL reset_ptrs got wp=%0d es=%0d cn=%0d exp 0/0/0", bus.o_wrt_ptr, bus.o_eseq, bus.o_consumed); end
    checks++; if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0) begin errs++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", bus.o_empty, bus.o_full); end
    checks++; if (bus.o_num_free_buff !== 9'd256) begin errs++; $display("FAIL reset_free got=%0d exp=256", bus.o_num_free_buff); end
    checks++; if (bus.o_llrb_valid !== 1'b0 || bus.o_replay_active !== 1'b0 || bus.o_replay_done !== 1'b0 || bus.o_wr_err !== 1'b0 || bus.o_ack_err !== 1'b0) begin errs++; $display("FAIL reset_pulses got v=%b a=%b d=%b we=%b ae=%b exp all 0", bus.o_llrb_valid, bus.o_replay_active, bus.o_replay_done, bus.o_wr_err, bus.o_ack_err); end
    #4; i_rst_n = 1;
    tick();
    checks++; if (bus.o_num_free_buff !== 9'd17) begin errs++; $display("FAIL wrap_load_free got=%0d exp=17", bus.o_num_free_buff); end
  endtask

  task automatic test_write3();
    do_reset(255);
    for (int i = 0; i < 3; i++) cycle(1, rand_flit(), 0, 0);
    checks++; if (bus.o_wrt_ptr !== 8'(m_wr) || m_wr != 3) begin errs++; $display("FAIL w3_wrt_ptr got=%0d exp=3", bus.o_wrt_ptr); end
    checks++; if (bus.o_eseq !== 8'd0) begin errs++; $display("FAIL w3_eseq got=%0d exp=0", bus.o_eseq); end
    checks++; if (bus.o_consumed !== 9'd3) begin errs++; $display("FAIL w3_consumed got=%0d exp=3", bus.o_consumed); end
    checks++; if (bus.o_num_free_buff !== 9'd253) begin errs++; $display("FAIL w3_free got=%0d exp=253", bus.o_num_free_buff); end
  endtask

  task automatic test_ack_replay();
    flit_t c;
    do_reset(255);
    for (int i = 0; i < 3; i++) cycle(1, rand_flit(), 0, 0);
    c = m_q[2];
    cycle(0, '0, 1, 2);
    checks++; if (bus.o_eseq !== 8'd2 || bus.o_consumed !== 9'd1) begin errs++; $display("FAIL ack2 got eseq=%0d cons=%0d exp 2/1", bus.o_eseq, bus.o_consumed); end
    run_replay(0, 0);
    checks++; if (r_first_active !== 1'b1 || r_active_bad != 0) begin errs++; $display("FAIL ar_active got first=%b drops=%0d exp 1/0", r_first_active, r_active_bad); end
    checks++; if (obs_q.size() != 1) begin errs++; $display("FAIL ar_count got=%0d exp=1", obs_q.size()); end
    else begin checks++; if (obs_q[0] !== c) begin errs++; $display("FAIL ar_flit got=%h exp=%h", obs_q[0][31:0], c[31:0]); end end
    checks++; if (!r_done || !r_coinc) begin errs++; $display("FAIL ar_done got done=%b with_valid=%b exp 1/1", r_done, r_coinc); end
    checks++; if (r_active_after !== 1'b0 || r_valid_after !== 1'b0) begin errs++; $display("FAIL ar_after got active=%b valid=%b exp 0/0", r_active_after, r_valid_after); end
  endtask

  task automatic test_wrap_full();
    do_reset(3);
    for (int i = 0; i < 4; i++) cycle(1, rand_flit(), 0, 0);
    checks++; if (bus.o_full !== 1'b1 || bus.o_wrt_ptr !== 8'd0) begin errs++; $display("FAIL wf_full got full=%b wp=%0d exp 1/0", bus.o_full, bus.o_wrt_ptr); end
    cycle(1, rand_flit(), 0, 0);
    checks++; if (bus.o_wr_err !== e_werr || !e_werr) begin errs++; $display("FAIL wf_wr_err got=%b exp=1", bus.o_wr_err); end
    checks++; if (bus.o_wrt_ptr !== 8'd0 || bus.o_consumed !== 9'd4) begin errs++; $display("FAIL wf_hold got wp=%0d cons=%0d exp 0/4", bus.o_wrt_ptr, bus.o_consumed); end
    cycle(0, '0, 1, 1);
    checks++; if (bus.o_wr_err !== 1'b0) begin errs++; $display("FAIL wf_err_pulse got=%b exp=0", bus.o_wr_err); end
    cycle(1, rand_flit(), 0, 0);
    checks++; if (bus.o_wrt_ptr !== 8'd1 || bus.o_eseq !== 8'd1 || bus.o_full !== 1'b1) begin errs++; $display("FAIL wf_wrap got wp=%0d es=%0d full=%b exp 1/1/1", bus.o_wrt_ptr, bus.o_eseq, bus.o_full); end
  endtask

  task automatic test_simul();
    do_reset(255);
    cycle(1, rand_flit(), 0, 0);
    cycle(1, rand_flit(), 0, 0);
    cycle(1, rand_flit(), 1, 1);
    checks++; if (bus.o_consumed !== 9'd2 || bus.o_ack_err !== 1'b0) begin errs++; $display("FAIL sim_wr_ack got cons=%0d aerr=%b exp 2/0", bus.o_consumed, bus.o_ack_err); end
    cycle(0, '0, 1, 9);
    checks++; if (bus.o_consumed !== 9'd0 || bus.o_ack_err !== 1'b1 || bus.o_empty !== 1'b1) begin errs++; $display("FAIL sim_clamp got cons=%0d aerr=%b empty=%b exp 0/1/1", bus.o_consumed, bus.o_ack_err, bus.o_empty); end
    checks++; if (bus.o_eseq !== 8'(m_eseq)) begin errs++; $display("FAIL sim_eseq got=%0d exp=%0d", bus.o_eseq, m_eseq); end
    cycle(0, '0, 1, 0);
    checks++; if (bus.o_ack_err !== 1'b0 || bus.o_eseq !== 8'(m_eseq)) begin errs++; $display("FAIL sim_ack0 got aerr=%b es=%0d exp 0/%0d", bus.o_ack_err, bus.o_eseq, m_eseq); end
  endtask

  task automatic test_replay_stall();
    flit_t exp_q[$];
    logic [7:0] wp;
    do_reset(255);
    for (int i = 0; i < 6; i++) cycle(1, rand_flit(), 0, 0);
    cycle(0, '0, 1, 2);
    exp_q = m_q;
    wp = bus.o_wrt_ptr;
    run_replay(1, 1);
    checks++; if (obs_q.size() != exp_q.size()) begin errs++; $display("FAIL rs_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errs++; $display("FAIL rs_flit%0d got=%h exp=%h", i, obs_q[i][31:0], exp_q[i][31:0]); end
    end
    checks++; if (r_werr !== 1'b1 || bus.o_wrt_ptr !== wp || bus.o_consumed !== 9'(m_q.size())) begin errs++; $display("FAIL rs_wr_block got werr=%b wp=%0d cons=%0d exp 1/%0d/%0d", r_werr, bus.o_wrt_ptr, bus.o_consumed, wp, m_q.size()); end
    checks++; if (!r_done || !r_coinc || r_active_bad != 0 || r_active_after !== 1'b0) begin errs++; $display("FAIL rs_ctrl got done=%b coinc=%b drops=%0d after=%b exp 1/1/0/0", r_done, r_coinc, r_active_bad, r_active_after); end
    // Empty buffer: done on the next cycle, no flits, no replay state.
    cycle(0, '0, 1, m_q.size());
    bus.i_replay_req = 1; tick(); bus.i_replay_req = 0;
    checks++; if (bus.o_replay_done !== 1'b1 || bus.o_llrb_valid !== 1'b0 || bus.o_replay_active !== 1'b0) begin errs++; $display("FAIL re_done got done=%b v=%b a=%b exp 1/0/0", bus.o_replay_done, bus.o_llrb_valid, bus.o_replay_active); end
    bus.i_rd_en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.o_llrb_valid !== 1'b0 || bus.o_replay_done !== 1'b0) begin errs++; $display("FAIL re_idle_rd got v=%b d=%b exp 0/0", bus.o_llrb_valid, bus.o_replay_done); end
    end
    bus.i_rd_en = 0;
  endtask

  task automatic test_random(input int wrap, input int ncyc);
    flit_t exp_q[$];
    do_reset(wrap);
    for (int k = 0; k < ncyc; k++) begin
      cycle($urandom_range(0, 9) < 6, rand_flit(), $urandom_range(0, 9) < 3, $urandom_range(0, 8));
      checks++; if (bus.o_consumed !== 9'(m_q.size()) || bus.o_num_free_buff !== 9'(m_wrap + 1 - m_q.size())) begin errs++; $display("FAIL rnd_count k=%0d got cons=%0d free=%0d exp %0d/%0d", k, bus.o_consumed, bus.o_num_free_buff, m_q.size(), m_wrap + 1 - m_q.size()); end
      checks++; if (bus.o_wrt_ptr !== 8'(m_wr) || bus.o_eseq !== 8'(m_eseq)) begin errs++; $display("FAIL rnd_ptr k=%0d got wp=%0d es=%0d exp %0d/%0d", k, bus.o_wrt_ptr, bus.o_eseq, m_wr, m_eseq); end
      checks++; if (bus.o_full !== (m_q.size() == m_wrap + 1) || bus.o_empty !== (m_q.size() == 0)) begin errs++; $display("FAIL rnd_flags k=%0d got full=%b empty=%b", k, bus.o_full, bus.o_empty); end
      checks++; if (bus.o_wr_err !== e_werr || bus.o_ack_err !== e_aerr) begin errs++; $display("FAIL rnd_err k=%0d got we=%b ae=%b exp %b/%b", k, bus.o_wr_err, bus.o_ack_err, e_werr, e_aerr); end
    end
    if (m_q.size() == 0) cycle(1, rand_flit(), 0, 0);
    exp_q = m_q;
    run_replay(0, 0);
    checks++; if (obs_q.size() != exp_q.size()) begin errs++; $display("FAIL rnd_replay_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errs++; $display("FAIL rnd_replay_flit%0d got=%h exp=%h", i, obs_q[i][31:0], exp_q[i][31:0]); end
    end
  endtask

  task automatic test_reset_mid_replay();
    do_reset(255);
    for (int i = 0; i < 3; i++) cycle(1, rand_flit(), 0, 0);
    bus.i_replay_req = 1; tick(); bus.i_replay_req = 0;
    bus.i_rd_en = 1; tick();
    #2; i_rst_n = 0; #1;
    checks++; if (bus.o_replay_active !== 1'b0 || bus.o_llrb_valid !== 1'b0 || bus.o_consumed !== 9'd0 || bus.o_empty !== 1'b1) begin errs++; $display("FAIL mid_reset got a=%b v=%b cons=%0d empty=%b exp 0/0/0/1", bus.o_replay_active, bus.o_llrb_valid, bus.o_consumed, bus.o_empty); end
    checks++; if (bus.o_replay_done !== 1'b0) begin errs++; $display("FAIL mid_reset_done got=%b exp=0", bus.o_replay_done); end
    bus.i_rd_en = 0;
    #3; i_rst_n = 1;
    tick();
    checks++; if (bus.o_replay_done !== 1'b0 || bus.o_replay_active !== 1'b0) begin errs++; $display("FAIL mid_reset_after got d=%b a=%b exp 0/0", bus.o_replay_done, bus.o_replay_active); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst_n = 1;
    clear_in();
    bus.i_llr_wrap_value = 8'hFF;
    test_reset();
    test_write3();
    test_ack_replay();
    test_wrap_full();
    test_simul();
    test_replay_stall();
    test_random(255, 300);
    test_random(5, 300);
    test_reset_mid_replay();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/retry_llrb.md
Name: retry_llrb

Overview:
- Link-layer retry buffer (LLRB) for the retry block.
- Captures every transmitted flit-with-CRC from the CRC generator and holds it until the remote side acknowledges it.
- On a local retry request, replays all unacknowledged flits in order to the TX MUX.
- Provides the write pointer, ESEQ, free-buffer count and consumed count consumed by the retry controller, control-flit packer and register file.

Parameters:
- FLIT_W, 528, flit width including CRC.
- DEPTH, 256, physical entries; pointers are 8 bits.

Ports:
- i_clk  in  1  single clock for the block.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wr_en  in  1  store i_flit_w_crc this cycle.
- i_flit_w_crc  in  FLIT_W  flit from the CRC generator.
- i_ack_valid  in  1  i_ack_num is valid this cycle.
- i_ack_num  in  8  number of oldest entries to free.
- i_replay_req  in  1  pulse; start a replay.
- i_rd_en  in  1  consumer pulls the next replay flit.
- i_llr_wrap_value  in  8  last valid pointer index; effective depth is wrap+1.
- o_llrb_flit  out  FLIT_W  replayed flit.
- o_llrb_valid  out  1  o_llrb_flit is valid this cycle.
- o_replay_active  out  1  replay is in progress.
- o_replay_done  out  1  one-cycle pulse at the end of a replay.
- o_wrt_ptr  out  8  next write index.
- o_eseq  out  8  index of the oldest unacknowledged entry.
- o_num_free_buff  out  9  (wrap+1) − count.
- o_consumed  out  9  count of unacknowledged entries.
- o_full  out  1  count == wrap+1.
- o_empty  out  1  count == 0.
- o_wr_err  out  1  one-cycle pulse; write dropped.
- o_ack_err  out  1  one-cycle pulse; ack was clamped.

Behaviour:
- Reset:
  - All pointers, counters, state and outputs go to 0, except o_empty=1 and o_num_free_buff=wrap+1 (combinational from the live wrap register).
  - The wrap register resets to 8'hFF.
  - The memory array is not reset.
- Wrap register:
  - Loads i_llr_wrap_value only in IDLE while count==0.
  - Otherwise the held value is used.
- Pointer increment: if ptr==wrap then 0, else ptr+1. Applies to wr_ptr, eseq and rd_ptr.
- Write:
  - Accepted when i_wr_en && !o_full && state==IDLE.
  - Stores at wr_ptr, advances wr_ptr, increments count.
  - Otherwise, if i_wr_en is asserted, the write is dropped, o_wr_err pulses next cycle, and no state changes.
- Ack:
  - n = min(i_ack_num, count); eseq advances by n with wrap, count −= n.
  - o_ack_err pulses when i_ack_num > count.
  - i_ack_num==0 is a no-op.
  - Acks are accepted in every state.
- Simultaneous write and ack: count_next = count + 1 − n, where n is computed against the pre-write count.
- FSM states: IDLE, REPLAY, FLUSH.
- IDLE:
  - On i_replay_req with count>0: rd_ptr<=eseq, remaining<=count, go to REPLAY, o_replay_active=1.
  - On i_replay_req with count==0: o_replay_done pulses next cycle and the FSM stays in IDLE.
- REPLAY:
  - Each i_rd_en reads mem[rd_ptr]; o_llrb_flit/o_llrb_valid appear exactly 1 cycle later.
  - rd_ptr advances, remaining decrements.
  - The read that takes remaining to 0 moves the FSM to FLUSH.
  - i_rd_en gaps stall the replay with no timeout.
  - i_replay_req is ignored.
  - Writes are blocked, so the replayed data stays intact even if acks free entries during the replay.
- FLUSH: the last flit's valid is asserted; o_replay_done pulses in the same cycle; go to IDLE; o_replay_active drops the following cycle.
- i_rd_en in IDLE is ignored and o_llrb_valid stays 0.
- Reset mid-replay returns the FSM to IDLE immediately with no done pulse.

Test Plan:
- Reset, then 3 writes (flits A,B,C) → o_wrt_ptr=3, o_eseq=0, o_consumed=3, o_num_free_buff=253.
- Write 3, ack i_ack_num=2 → o_eseq=2, o_consumed=1; then i_replay_req with i_rd_en held high → o_llrb_flit=C 1 cycle after the read, valid for exactly 1 cycle, o_replay_done coincident with it, o_replay_active high for the replay duration.
- Wrap=3, write 4 → o_full=1; 5th write → o_wr_err pulse and o_wrt_ptr stays 0; ack 1 then write → o_wrt_ptr=1 (wrapped), o_eseq=1.
- Write and ack(1) in the same cycle with count=2 → o_consumed stays 2; ack 9 with count=2 → o_consumed=0, o_ack_err=1.
- Replay of 4 flits with i_rd_en toggled every other cycle and a write attempted mid-replay → 4 valid flits in order, o_wr_err pulse, o_wrt_ptr unchanged; i_replay_req with count=0 → o_replay_done next cycle and no valid flits.
- i_rst_n asserted during REPLAY → o_replay_active=0, o_llrb_valid=0, o_consumed=0, o_empty=1 asynchronously.
